// File: rtl/cache_dre_ri_ctrl_pkg.sv
// Shared types and constants for the DRE (per-byte readable bit) maintenance controller.
package cache_dre_pkg;

  typedef enum logic [1:0] {
    OP_QUERY = 2'd0,
    OP_CLEAR = 2'd1,
    OP_FILL  = 2'd2,
    OP_MERGE = 2'd3
  } dre_op_e;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_EXEC = 3'd2,
    ST_RD   = 3'd3,
    ST_RMW  = 3'd4
  } dre_state_e;

  localparam logic [7:0] DRE_EMPTY = 8'h00;
  localparam logic [7:0] DRE_FULL  = 8'hFF;

  // Number of sweep writes needed to clear every entry of all four channels.
  function automatic int unsigned init_cycles(input int unsigned addrWidth);
    return 4 * (32'd1 << (addrWidth - 1));
  endfunction

endpackage

// File: rtl/cache_dre_ri_ctrl_if.sv
// Command/response and ri-side DRE store signals of the maintenance controller.
interface cache_dre_ri_ctrl_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [1:0]            cmd_ch;
  logic [7:0]            cmd_mask;
  logic                  rsp_valid;
  logic [7:0]            rsp_mask;
  logic                  init_done;
  logic                  sel;
  logic [ADDR_WIDTH-1:0] ri_readAddress;
  logic [1:0]            ri_readChannel;
  logic [7:0]            ri_readData;
  logic [ADDR_WIDTH-1:0] ri_writeAddress;
  logic [1:0]            ri_writeChannel;
  logic                  ri_writeEnable;
  logic [7:0]            ri_writeData;

  // Requester side plus the DRE store model (supplies read data).
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_ch, cmd_mask, ri_readData,
    input  cmd_ready, rsp_valid, rsp_mask, init_done, sel,
           ri_readAddress, ri_readChannel, ri_writeAddress, ri_writeChannel,
           ri_writeEnable, ri_writeData
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_ch, cmd_mask, ri_readData,
    output cmd_ready, rsp_valid, rsp_mask, init_done, sel,
           ri_readAddress, ri_readChannel, ri_writeAddress, ri_writeChannel,
           ri_writeEnable, ri_writeData
  );
endinterface

// File: rtl/cache_dre_ri_ctrl.sv
// DRE maintenance controller: clears the whole store after reset, then serves
// single-entry QUERY/CLEAR/FILL/MERGE commands while owning the store mux (sel).
module cache_dre_ri_ctrl
  import cache_dre_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input logic               clk,
  input logic               rst_n,
  cache_dre_ri_ctrl_if.slave bus
);

  localparam int CNT_W = ADDR_WIDTH + 2;
  localparam logic [CNT_W-1:0] INIT_END = CNT_W'(init_cycles(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] ENTRY_MASK = ~(ADDR_WIDTH'(1));

  localparam logic [2:0] S_INIT = ST_INIT;
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_EXEC = ST_EXEC;
  localparam logic [2:0] S_RD   = ST_RD;
  localparam logic [2:0] S_RMW  = ST_RMW;

  if (NUM_CH != 4) begin : gChCheck
    $error("cache_dre_ri_ctrl supports exactly 4 channels");
  end

  logic [2:0]            state;
  logic [CNT_W-1:0]      sweepCnt;
  logic [1:0]            opR;
  logic [ADDR_WIDTH-1:0] addrR;
  logic [1:0]            chR;
  logic [7:0]            maskR;
  logic [7:0]            rspMaskR;
  logic [7:0]            writeDataR;
  logic                  cmdReady;
  logic                  rspValid;
  logic                  initDone;
  logic                  selR;
  logic [ADDR_WIDTH-1:0] readAddrR;
  logic [1:0]            readChR;
  logic [ADDR_WIDTH-1:0] writeAddrR;
  logic [1:0]            writeChR;
  logic                  writeEnR;

  logic [ADDR_WIDTH-1:0] cmdEntry;
  logic [7:0]            cmdWord;
  logic [7:0]            mergeVal;

  // Entry-level address of the incoming command and the word CLEAR/FILL write.
  always_comb begin
    cmdEntry = bus.cmd_addr & ENTRY_MASK;
    cmdWord  = (bus.cmd_op == OP_FILL) ? DRE_FULL : DRE_EMPTY;
  end

  // Read data arrives in the RMW cycle; QUERY passes it through, MERGE ORs the mask in.
  always_comb begin
    mergeVal = bus.ri_readData | ((opR == OP_MERGE) ? maskR : DRE_EMPTY);
  end

  // Main FSM: init sweep, command acceptance and the one-cycle execution states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      sweepCnt   <= '0;
      opR        <= '0;
      addrR      <= '0;
      chR        <= '0;
      maskR      <= '0;
      rspMaskR   <= '0;
      writeDataR <= '0;
      cmdReady   <= 1'b0;
      rspValid   <= 1'b0;
      initDone   <= 1'b0;
      selR       <= 1'b1;
      readAddrR  <= '0;
      readChR    <= '0;
      writeAddrR <= '0;
      writeChR   <= '0;
      writeEnR   <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (sweepCnt == INIT_END) begin
            state    <= S_IDLE;
            initDone <= 1'b1;
            cmdReady <= 1'b1;
            selR     <= 1'b0;
            writeEnR <= 1'b0;
          end else begin
            // Channel sits in the low bits so it advances first.
            writeEnR   <= 1'b1;
            writeAddrR <= {sweepCnt[CNT_W-2:2], 1'b0};
            writeChR   <= sweepCnt[1:0];
            writeDataR <= DRE_EMPTY;
            sweepCnt   <= sweepCnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmdReady <= 1'b0;
            selR     <= 1'b1;
            opR      <= bus.cmd_op;
            addrR    <= cmdEntry;
            chR      <= bus.cmd_ch;
            maskR    <= bus.cmd_mask;
            if (bus.cmd_op == OP_CLEAR || bus.cmd_op == OP_FILL) begin
              state      <= S_EXEC;
              writeEnR   <= 1'b1;
              writeAddrR <= cmdEntry;
              writeChR   <= bus.cmd_ch;
              writeDataR <= cmdWord;
              rspMaskR   <= cmdWord;
              rspValid   <= 1'b1;
            end else begin
              state     <= S_RD;
              readAddrR <= cmdEntry;
              readChR   <= bus.cmd_ch;
            end
          end
        end
        S_EXEC: begin
          state    <= S_IDLE;
          selR     <= 1'b0;
          writeEnR <= 1'b0;
          rspValid <= 1'b0;
          cmdReady <= 1'b1;
        end
        S_RD: begin
          // Read address stays put: the RAM applies channel select after its register.
          state      <= S_RMW;
          writeEnR   <= (opR == OP_MERGE);
          writeAddrR <= addrR;
          writeChR   <= chR;
          rspValid   <= 1'b1;
        end
        S_RMW: begin
          state      <= S_IDLE;
          rspMaskR   <= mergeVal;
          writeDataR <= mergeVal;
          rspValid   <= 1'b0;
          writeEnR   <= 1'b0;
          selR       <= 1'b0;
          cmdReady   <= 1'b1;
        end
        default: begin
          state    <= S_INIT;
          sweepCnt <= '0;
          selR     <= 1'b1;
          writeEnR <= 1'b0;
          cmdReady <= 1'b0;
          rspValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready       = cmdReady;
  assign bus.rsp_valid       = rspValid;
  assign bus.rsp_mask        = (state == S_RMW) ? mergeVal : rspMaskR;
  assign bus.init_done       = initDone;
  assign bus.sel             = selR;
  assign bus.ri_readAddress  = readAddrR;
  assign bus.ri_readChannel  = readChR;
  assign bus.ri_writeAddress = writeAddrR;
  assign bus.ri_writeChannel = writeChR;
  assign bus.ri_writeEnable  = writeEnR;
  assign bus.ri_writeData    = (state == S_RMW) ? mergeVal : writeDataR;

endmodule

// File: tb/tb_cache_dre_ri_ctrl.sv
// Directed bench for cache_dre_ri_ctrl with a synchronous DRE store model.
module tb_cache_dre_ri_ctrl;
  import cache_dre_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   monOn;
  logic prevRsp;
  logic scramble;

  logic [7:0] mem    [4][128];
  logic [7:0] refMem [4][128];

  cache_dre_ri_ctrl_if #(.ADDR_WIDTH(8)) bus ();

  cache_dre_ri_ctrl #(.ADDR_WIDTH(8), .NUM_CH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous store: registered read, write at the clock edge; scramble preloads junk.
  always @(posedge clk) begin
    if (scramble) begin
      for (int c = 0; c < 4; c++)
        for (int e = 0; e < 128; e++)
          mem[c][e] <= 8'h5A;
    end else begin
      bus.ri_readData <= mem[bus.ri_readChannel][bus.ri_readAddress[7:1]];
      if (bus.ri_writeEnable)
        mem[bus.ri_writeChannel][bus.ri_writeAddress[7:1]] <= bus.ri_writeData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants: no ri write without ownership, sel low only while ready, single-cycle rsp.
  always @(negedge clk) begin
    if (monOn) begin
      checks++;
      assert (!(bus.ri_writeEnable && !bus.sel)) else begin
        errors++;
        $error("FAIL we_without_sel: observed we=%0b sel=%0b expected no write", bus.ri_writeEnable, bus.sel);
      end
      checks++;
      assert (bus.sel === ~bus.cmd_ready) else begin
        errors++;
        $error("FAIL sel_vs_ready: observed sel=%0b ready=%0b expected sel=~ready", bus.sel, bus.cmd_ready);
      end
      checks++;
      assert (!(prevRsp && bus.rsp_valid)) else begin
        errors++;
        $error("FAIL rsp_pulse: observed rsp_valid high 2 cycles expected 1");
      end
      prevRsp = bus.rsp_valid;
    end
  end

  // Follows the sweep from reset release until init_done, recording write coverage.
  task automatic waitInit(output int writes, output int covered, output int badData,
                          output int readyHi, output int gap, output bit timedOut);
    bit seen [512];
    int cyc;
    int lastW;
    int idx;
    writes = 0; covered = 0; badData = 0; readyHi = 0; cyc = 0; lastW = 0;
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    while (!bus.init_done && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (bus.init_done) break;
      if (bus.ri_writeEnable) begin
        writes++;
        idx = {bus.ri_writeAddress[7:1], bus.ri_writeChannel};
        if (!seen[idx]) covered++;
        seen[idx] = 1'b1;
        if (bus.ri_writeData !== 8'h00) badData++;
        lastW = cyc;
      end
      if (bus.cmd_ready) readyHi++;
    end
    timedOut = !bus.init_done;
    gap = cyc - lastW;
  endtask

  // Issues one command from a negedge and returns the response mask and latency in cycles.
  task automatic doCmd(input logic [1:0] op, input logic [7:0] addr, input logic [1:0] ch,
                       input logic [7:0] mask, output logic [7:0] m, output int lat);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(n < 50), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_ch    = ch;
    bus.cmd_mask  = mask;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 99;
    m   = 8'hxx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        m   = bus.rsp_mask;
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int writes, covered, badData, readyHi, gap, lat, rspSeen;
    bit timedOut;
    logic [7:0] m, expM, a, mk;
    logic [1:0] op, ch;

    checks = 0; errors = 0; monOn = 1'b0; prevRsp = 1'b0;
    scramble = 1'b1;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = 8'h00;
    bus.cmd_ch = 2'd0; bus.cmd_mask = 8'h00;
    repeat (3) @(negedge clk);
    scramble = 1'b0;
    monOn = 1'b1;

    // Reset values
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_mask", 32'(bus.rsp_mask), 32'h00);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd1);
    chk("rst_we", 32'(bus.ri_writeEnable), 32'd0);
    chk("rst_raddr", 32'(bus.ri_readAddress), 32'h00);
    chk("rst_waddr", 32'(bus.ri_writeAddress), 32'h00);
    chk("rst_wdata", 32'(bus.ri_writeData), 32'h00);

    // Release with a MERGE held pending through the whole sweep
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_MERGE; bus.cmd_addr = 8'h40;
    bus.cmd_ch = 2'd0; bus.cmd_mask = 8'h3C;
    rst_n = 1'b1;
    waitInit(writes, covered, badData, readyHi, gap, timedOut);
    chk("init_timeout", 32'(timedOut), 32'd0);
    chk("init_writes", 32'(writes), 32'd512);
    chk("init_coverage", 32'(covered), 32'd512);
    chk("init_data", 32'(badData), 32'd0);
    chk("init_ready_low", 32'(readyHi), 32'd0);
    chk("init_done_gap", 32'(gap), 32'd1);
    chk("idle_sel", 32'(bus.sel), 32'd0);
    @(negedge clk);
    chk("held_rd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("held_rd_sel", 32'(bus.sel), 32'd1);
    chk("held_rd_raddr", 32'(bus.ri_readAddress), 32'h40);
    chk("held_rd_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("held_rmw_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("held_rmw_mask", 32'(bus.rsp_mask), 32'h3C);
    chk("held_rmw_we", 32'(bus.ri_writeEnable), 32'd1);
    chk("held_rmw_wdata", 32'(bus.ri_writeData), 32'h3C);
    chk("held_rmw_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("held_back_idle", 32'(bus.cmd_ready), 32'd1);

    // Directed commands
    doCmd(OP_QUERY, 8'hFE, 2'd3, 8'h00, m, lat);
    chk("q_fe_mask", 32'(m), 32'h00);
    chk("q_fe_lat", 32'(lat), 32'd2);
    doCmd(OP_FILL, 8'h10, 2'd2, 8'h00, m, lat);
    chk("fill_mask", 32'(m), 32'hFF);
    chk("fill_lat", 32'(lat), 32'd1);
    doCmd(OP_QUERY, 8'h11, 2'd2, 8'h00, m, lat);
    chk("q_bit0_ignored", 32'(m), 32'hFF);
    doCmd(OP_QUERY, 8'h10, 2'd1, 8'h00, m, lat);
    chk("q_other_ch", 32'(m), 32'h00);
    doCmd(OP_MERGE, 8'h20, 2'd1, 8'h0F, m, lat);
    chk("merge_0f", 32'(m), 32'h0F);
    chk("merge_lat", 32'(lat), 32'd2);
    doCmd(OP_MERGE, 8'h20, 2'd1, 8'hF0, m, lat);
    chk("merge_f0", 32'(m), 32'hFF);
    doCmd(OP_CLEAR, 8'h20, 2'd1, 8'h00, m, lat);
    chk("clear_mask", 32'(m), 32'h00);
    chk("clear_lat", 32'(lat), 32'd1);
    doCmd(OP_QUERY, 8'h20, 2'd1, 8'h00, m, lat);
    chk("q_after_clear", 32'(m), 32'h00);
    doCmd(OP_QUERY, 8'h40, 2'd0, 8'h00, m, lat);
    chk("q_held_merge", 32'(m), 32'h3C);
    @(negedge clk);
    chk("rsp_mask_held", 32'(bus.rsp_mask), 32'h3C);

    // Reset during the RD cycle of a MERGE
    doCmd(OP_MERGE, 8'h20, 2'd1, 8'h81, m, lat);
    chk("pre_rst_merge", 32'(m), 32'h81);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_MERGE; bus.cmd_addr = 8'h20;
    bus.cmd_ch = 2'd1; bus.cmd_mask = 8'h18;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_rd_raddr", 32'(bus.ri_readAddress), 32'h20);
    rst_n = 1'b0;
    #1;
    chk("async_sel", 32'(bus.sel), 32'd1);
    chk("async_raddr", 32'(bus.ri_readAddress), 32'h00);
    chk("async_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("async_rsp_mask", 32'(bus.rsp_mask), 32'h00);
    rspSeen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) rspSeen++;
    end
    chk("abort_no_rsp", 32'(rspSeen), 32'd0);
    rst_n = 1'b1;
    waitInit(writes, covered, badData, readyHi, gap, timedOut);
    chk("reinit_timeout", 32'(timedOut), 32'd0);
    chk("reinit_writes", 32'(writes), 32'd512);
    chk("reinit_coverage", 32'(covered), 32'd512);
    doCmd(OP_QUERY, 8'h20, 2'd1, 8'h00, m, lat);
    chk("q_after_reinit", 32'(m), 32'h00);
    doCmd(OP_QUERY, 8'h10, 2'd2, 8'h00, m, lat);
    chk("q_fill_cleared", 32'(m), 32'h00);

    // Random ops against a reference table
    for (int c = 0; c < 4; c++)
      for (int e = 0; e < 128; e++)
        refMem[c][e] = 8'h00;
    for (int t = 0; t < 60; t++) begin
      op = 2'($urandom_range(3));
      ch = 2'($urandom_range(3));
      a  = 8'($urandom_range(255));
      if (t % 4 == 0) a = {a[7:4], 4'h6};
      mk = 8'($urandom_range(255));
      case (op)
        OP_QUERY: expM = refMem[ch][a[7:1]];
        OP_CLEAR: expM = 8'h00;
        OP_FILL:  expM = 8'hFF;
        default:  expM = refMem[ch][a[7:1]] | mk;
      endcase
      if (op != OP_QUERY) refMem[ch][a[7:1]] = expM;
      doCmd(op, a, ch, mk, m, lat);
      chk($sformatf("rand%0d_mask", t), 32'(m), 32'(expM));
      chk($sformatf("rand%0d_lat", t), 32'(lat),
          (op == OP_CLEAR || op == OP_FILL) ? 32'd1 : 32'd2);
    end

    repeat (3) @(negedge clk);
    monOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_dre_ri_ctrl.md
Name: cache_dre_ri_ctrl

Overview:
- Maintenance controller that drives the ri_* side of the per-byte readable-bit (DRE) store and owns its `sel` mux.
- After reset it clears every DRE entry in all 4 channels.
- It then serves single-entry commands from the refill/replacement logic: QUERY, CLEAR, FILL and MERGE (read-modify-write).
- While it is busy, the rw path is locked out of the DRE store.

Parameters:
- ADDR_WIDTH, 8, DRE address width. Entry index is addr[ADDR_WIDTH-1:1]; each entry holds 8 bits (two 4-bit word masks).
- NUM_CH, 4, channel (way) count. Fixed at 4; the parameter exists for assertions only.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted on clk edge when cmd_valid&cmd_ready
- cmd_op  in  2  0 QUERY, 1 CLEAR, 2 FILL, 3 MERGE
- cmd_addr  in  ADDR_WIDTH  DRE address; bit0 ignored (entry-level op)
- cmd_ch  in  2  channel
- cmd_mask  in  8  OR-mask for MERGE
- rsp_valid  out  1  one-cycle completion pulse
- rsp_mask  out  8  QUERY: stored mask; MERGE: new mask; CLEAR: 0x00; FILL: 0xFF
- init_done  out  1  high once the init sweep completes; stays high until reset
- sel  out  1  high = ri side owns the DRE store
- ri_readAddress  out  ADDR_WIDTH  read address
- ri_readChannel  out  2  read channel
- ri_readData  in  8  full 8-bit entry, valid 1 cycle after address (synchronous RAM)
- ri_writeAddress  out  ADDR_WIDTH  write address
- ri_writeChannel  out  2  write channel
- ri_writeEnable  out  1  write strobe
- ri_writeData  out  8  entry write data

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT; sweep counter=0.
  - cmd_ready=0, rsp_valid=0, rsp_mask=0, init_done=0, sel=1, ri_writeEnable=0.
  - All ri_* addresses/channels and ri_writeData = 0.
- States: INIT, IDLE, EXEC, RD, RMW.
- INIT:
  - One write per cycle with data 0x00. Counter = {entry index, channel}; channel is the low 2 bits and increments first.
  - ri_writeAddress = {index, 1'b0}.
  - Total 4*2^(ADDR_WIDTH-1) cycles (512 at default).
  - After the last write: init_done=1, state goes to IDLE.
- IDLE: sel=0, cmd_ready=1. Accepting a command registers op/addr/ch/mask, then:
  - CLEAR/FILL go to EXEC.
  - QUERY/MERGE go to RD.
- cmd_ready=0 in every state except IDLE. Commands are strictly serialised; maximum one outstanding.
- EXEC (1 cycle): sel=1; ri_writeEnable=1; data 0x00 (CLEAR) or 0xFF (FILL); rsp_valid=1 in the same cycle. Next state IDLE.
- RD (1 cycle): sel=1; ri_readAddress/ri_readChannel driven from the registered command. Next state RMW.
- RMW (1 cycle):
  - sel=1; ri_readAddress and ri_readChannel are held unchanged, because channel select is applied after the RAM register.
  - QUERY: rsp_mask=ri_readData, rsp_valid=1.
  - MERGE: ri_writeData = ri_readData|mask; ri_writeEnable=1; rsp_mask = same value; rsp_valid=1.
  - Next state IDLE.
- Latency from acceptance edge T:
  - CLEAR/FILL: rsp_valid during cycle T+1.
  - QUERY/MERGE: rsp_valid during cycle T+2.
- sel is registered together with the address outputs, so the mux switches in the same cycle the addresses become valid. There is no glitch cycle where rw addresses reach the RAM with ri write enable.
- ri_writeEnable is never asserted while sel=0.
- rsp_valid is a single-cycle pulse. rsp_mask holds its last value until the next response.
- Back-to-back commands to the same entry: the write lands at the end of the completing cycle; the next command's read is at least 1 cycle later, so no bypass is needed.
- Reset mid-operation: abort immediately, no response, restart the INIT sweep. A partial MERGE write is irrelevant because INIT clears everything.
- cmd_valid during INIT is ignored (not accepted, not queued).

Decomposition:
- Package cache_dre_pkg:
  - dre_op_e (QUERY/CLEAR/FILL/MERGE)
  - dre_state_e
  - DRE_EMPTY=8'h00, DRE_FULL=8'hFF
  - function init_cycles(ADDR_WIDTH)
- No sub-module. Single FSM with a sweep counter; the counter is inline.

Test Plan:
- Reset release: init_done rises after exactly 512 cycles with 512 write strobes covering every {index, ch}. QUERY ch3 addr 0xFE returns 0x00.
- FILL ch2 addr 0x10 → rsp at T+1 with 0xFF. Then QUERY ch2 addr 0x11 returns 0xFF (bit0 ignored), and QUERY ch1 addr 0x10 returns 0x00.
- MERGE ch1 addr 0x20 mask 0x0F returns 0x0F. MERGE mask 0xF0 returns 0xFF. CLEAR returns 0x00; a following QUERY returns 0x00.
- cmd_valid held high continuously through INIT and a MERGE: exactly one accept per IDLE cycle, cmd_ready=0 otherwise, sel=0 only in IDLE.
- rst_n pulsed low during the MERGE RD cycle: no rsp_valid, outputs at reset values asynchronously, full INIT re-sweep, then QUERY of that entry returns 0x00.
- Randomised ops against a 4×128×8 reference model, checking every rsp_mask and that ri_writeEnable is never asserted while sel=0.
